// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage of a simple in-order pipeline. Holds the fetch
//   PC (pc_f), drives a combinational instruction memory, and registers the
//   fetched word into the F/R pipeline register (inst_r, pc_r, valid_r).
//   A RUN/HALT state machine stops fetching once a halt instruction has been
//   loaded into inst_r. Only a branch redirect or reset resumes fetching.
//
// Parameters
//   RESET_PC  PC value loaded at reset
//   NOP_INST  bubble encoding placed in inst_r when no instruction is loaded
//   HLT_INST  halt instruction encoding
//
// Ports
//   clk            single clock, rising edge
//   rst            asynchronous active-high reset
//   en_f           fetch enable from the pipeline controller
//   en_r           R-stage register enable from the pipeline controller
//   branch_taken   redirect request from X stage (highest priority)
//   branch_target  redirect address
//   imem_addr      instruction memory word address (equals pc_f)
//   imem_data      instruction word, combinational read of imem_addr
//   inst_r         instruction presented to the R stage
//   pc_r           address+1 of inst_r
//   valid_r        inst_r holds a real fetched instruction
//   halted         registered copy of (state == HALT)
//   fetch_count    saturating count of instructions loaded into inst_r
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = 16'h0000,
  parameter logic [15:0] HLT_INST = 16'h2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_f,
  input  logic        en_r,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] inst_r,
  output logic [15:0] pc_r,
  output logic        valid_r,
  output logic        halted,
  output logic [15:0] fetch_count
);

  localparam int unsigned W = 16;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t       state;
  logic [W-1:0] pc_f;
  logic [W-1:0] pc_inc_c;
  logic         load_c;
  logic         bubble_c;

  // Memory is addressed straight from the fetch PC register.
  assign imem_addr = pc_f;

  // Next sequential address; 16-bit arithmetic wraps FFFF -> 0000.
  assign pc_inc_c = pc_f + W'(1);

  // A real load needs both enables: en_f without en_r must neither advance
  // the PC nor overwrite inst_r, so the word at pc_f is fetched again later.
  assign load_c = !branch_taken && en_r && en_f && (state == RUN);

  // R stage accepts a new value but there is nothing to fetch: insert bubble.
  assign bubble_c = !branch_taken && en_r && !(en_f && (state == RUN));

  // Fetch PC, F/R pipeline register, run/halt state and fetch counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      halted      <= 1'b0;
      pc_f        <= RESET_PC;
      inst_r      <= NOP_INST;
      pc_r        <= '0;
      valid_r     <= 1'b0;
      fetch_count <= '0;
    end else if (branch_taken) begin
      // Redirect wins over everything, squashes inst_r and leaves HALT.
      state   <= RUN;
      halted  <= 1'b0;
      pc_f    <= branch_target;
      inst_r  <= NOP_INST;
      valid_r <= 1'b0;
    end else if (load_c) begin
      pc_f    <= pc_inc_c;
      inst_r  <= imem_data;
      pc_r    <= pc_inc_c;
      valid_r <= 1'b1;
      if (fetch_count != '1) begin
        fetch_count <= fetch_count + W'(1);
      end
      // The halt word itself is delivered as a valid instruction.
      if (imem_data == HLT_INST) begin
        state  <= HALT;
        halted <= 1'b1;
      end
    end else if (bubble_c) begin
      inst_r  <= NOP_INST;
      valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//   Directed scenarios followed by randomized enables/branches/resets, all
//   compared cycle by cycle against a behavioural model of the fetch rules,
//   then a long run to exercise fetch_count saturation.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [15:0] NOP = 16'h0000;
  localparam logic [15:0] HLT = 16'h2000;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_f;
  logic        en_r;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] inst_r;
  logic [15:0] pc_r;
  logic        valid_r;
  logic        halted;
  logic [15:0] fetch_count;

  logic [15:0] imem [0:65535];

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state
  logic [15:0] m_pc, m_inst, m_pcr, m_cnt;
  logic        m_valid, m_halt;

  always #5 clk = ~clk;

  assign imem_data = imem[imem_addr];

  fetch_stage #(
    .RESET_PC(16'h0000),
    .NOP_INST(NOP),
    .HLT_INST(HLT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en_f         (en_f),
    .en_r         (en_r),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .inst_r       (inst_r),
    .pc_r         (pc_r),
    .valid_r      (valid_r),
    .halted       (halted),
    .fetch_count  (fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".imem_addr"},   32'(imem_addr),   32'(m_pc));
    check({tag, ".inst_r"},      32'(inst_r),      32'(m_inst));
    check({tag, ".pc_r"},        32'(pc_r),        32'(m_pcr));
    check({tag, ".valid_r"},     32'(valid_r),     32'(m_valid));
    check({tag, ".halted"},      32'(halted),      32'(m_halt));
    check({tag, ".fetch_count"}, 32'(fetch_count), 32'(m_cnt));
  endtask

  task automatic model_reset();
    m_pc    = 16'h0000;
    m_inst  = NOP;
    m_pcr   = 16'h0000;
    m_valid = 1'b0;
    m_halt  = 1'b0;
    m_cnt   = 16'h0000;
  endtask

  task automatic drive(input logic ef, input logic er, input logic br, input logic [15:0] tgt);
    en_f          = ef;
    en_r          = er;
    branch_taken  = br;
    branch_target = tgt;
  endtask

  // Advance one clock: model computes the next state from the current
  // inputs, then outputs are sampled 1 time unit after the rising edge.
  task automatic step(input string tag, input bit do_cmp);
    logic [15:0] word;
    word = imem[m_pc];
    if (branch_taken) begin
      m_pc    = branch_target;
      m_inst  = NOP;
      m_valid = 1'b0;
      m_halt  = 1'b0;
    end else if (en_r) begin
      if (en_f && !m_halt) begin
        m_inst  = word;
        m_pcr   = m_pc + 16'd1;
        m_pc    = m_pc + 16'd1;
        m_valid = 1'b1;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (word == HLT) m_halt = 1'b1;
      end else begin
        m_inst  = NOP;
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    if (do_cmp) check_all(tag);
  endtask

  // Assert reset between edges; outputs must change before any edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all({tag, ".async"});
    @(posedge clk);
    #1;
    check_all({tag, ".held"});
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) imem[i] = 16'h8000 | 16'(i);
    for (int i = 0; i < 4; i++) imem[i] = 16'h1000 + 16'(i);
    imem[5] = HLT;

    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    rst = 1'b1;
    #1;
    model_reset();
    check_all("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Straight-line fetch of four words
    drive(1'b1, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      step("seq", 1'b1);
      check("seq.inst_const", 32'(inst_r), 32'(16'h1000 + 16'(i)));
      check("seq.pcr_const",  32'(pc_r),   32'(i + 1));
    end
    check("seq.count_const", 32'(fetch_count), 32'd4);

    // Stall two cycles, then a bubble with en_r only
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    step("stall0", 1'b1);
    step("stall1", 1'b1);
    check("stall.inst_held", 32'(inst_r), 32'h1003);
    drive(1'b0, 1'b1, 1'b0, 16'h0000);
    step("bubble", 1'b1);
    check("bubble.valid", 32'(valid_r), 32'd0);
    check("bubble.addr",  32'(imem_addr), 32'h0004);

    // Illegal en_f without en_r: nothing moves
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    step("illegal", 1'b1);

    // Branch while stalled, then fetch from the target
    drive(1'b0, 1'b0, 1'b1, 16'h0040);
    step("br", 1'b1);
    check("br.addr", 32'(imem_addr), 32'h0040);
    drive(1'b1, 1'b1, 1'b0, 16'h0000);
    step("br.fetch", 1'b1);
    check("br.inst", 32'(inst_r), 32'h8040);

    // Halt at imem[5]
    async_reset("rst2");
    drive(1'b1, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 6; i++) step("toHLT", 1'b1);
    check("hlt.inst",   32'(inst_r),    32'(HLT));
    check("hlt.valid",  32'(valid_r),   32'd1);
    check("hlt.halted", 32'(halted),    32'd1);
    check("hlt.addr",   32'(imem_addr), 32'h0006);
    step("halted1", 1'b1);
    step("halted2", 1'b1);
    check("halted.inst", 32'(inst_r), 32'(NOP));
    check("halted.addr", 32'(imem_addr), 32'h0006);
    drive(1'b1, 1'b1, 1'b1, 16'h0010);
    step("hlt.br", 1'b1);
    check("hlt.br.halted", 32'(halted), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 16'h0000);
    step("resume", 1'b1);
    check("resume.inst", 32'(inst_r), 32'h8010);

    // Reset asserted while halted
    drive(1'b1, 1'b1, 1'b1, 16'h0000);
    step("rehalt.br", 1'b1);
    drive(1'b1, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 6; i++) step("rehalt", 1'b1);
    check("rehalt.halted", 32'(halted), 32'd1);
    async_reset("rst_halt");

    // PC wrap from FFFF
    drive(1'b0, 1'b0, 1'b1, 16'hFFFF);
    step("wrap.br", 1'b1);
    drive(1'b1, 1'b1, 1'b0, 16'h0000);
    step("wrap", 1'b1);
    check("wrap.addr", 32'(imem_addr), 32'h0000);
    check("wrap.pcr",  32'(pc_r),      32'h0000);

    // Randomized enables, branches, halts and resets
    imem[17]  = HLT;
    imem[100] = HLT;
    imem[200] = HLT;
    for (int c = 0; c < 1500; c++) begin
      if (c % 300 == 299) begin
        async_reset("rnd.rst");
      end else begin
        drive(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 16) == 0,
              16'($urandom_range(0, 255)));
        step("rnd", 1'b1);
      end
    end

    // Run long enough for fetch_count to saturate
    for (int i = 0; i < 65536; i++) imem[i] = 16'h8000 | 16'(i);
    async_reset("rst_sat");
    drive(1'b1, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 65540; i++) step("sat", 1'b0);
    check_all("sat");
    check("sat.const", 32'(fetch_count), 32'h0000FFFF);
    step("sat.more", 1'b1);
    check("sat.more.const", 32'(fetch_count), 32'h0000FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000: PC value loaded at reset.
REQ-002 SHALL have parameter NOP_INST, default 16'h0000: bubble encoding, decoding to no register source or destination.
REQ-003 SHALL have parameter HLT_INST, default 16'h2000: halt instruction encoding.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 en_f  in  1  fetch enable from pipeline controller.
REQ-007 en_r  in  1  R-stage register enable from pipeline controller.
REQ-008 branch_taken  in  1  redirect request from X stage.
REQ-009 branch_target  in  16  redirect address.
REQ-010 imem_addr  out  16  instruction memory word address, equal to pc_f.
REQ-011 imem_data  in  16  instruction word, combinational read of imem_addr.
REQ-012 inst_r  out  16  instruction presented to R stage.
REQ-013 pc_r  out  16  address+1 of inst_r.
REQ-014 valid_r  out  1  inst_r is a real fetched instruction, not a bubble.
REQ-015 halted  out  1  state is HALT.
REQ-016 fetch_count  out  16  number of valid instructions loaded into inst_r.

Function
REQ-017 SHALL hold a state register with states RUN and HALT.
REQ-018 pc_f update priority: branch_taken, then en_f in RUN, then hold.
REQ-019 branch_taken=1: pc_f <= branch_target; inst_r <= NOP_INST; valid_r <= 0; state <= RUN. Applies regardless of en_f/en_r and in either state.
REQ-020 RUN, en_f=1, no branch: pc_f <= pc_f+1, modulo 2^16 (16'hFFFF wraps to 16'h0000).
REQ-021 HALT, no branch: pc_f SHALL hold regardless of en_f.
REQ-022 en_r=1, en_f=1, RUN, no branch: inst_r <= imem_data; pc_r <= pc_f+1 (mod 2^16); valid_r <= 1.
REQ-023 en_r=1 and (en_f=0 or HALT), no branch: inst_r <= NOP_INST; valid_r <= 0; pc_r holds.
REQ-024 en_r=0, no branch: inst_r, pc_r, valid_r SHALL hold.
REQ-025 en_f=1 with en_r=0 is illegal input; pc_f SHALL NOT advance, and no instruction SHALL be lost.
REQ-026 RUN to HALT occurs when REQ-022 loads imem_data equal to HLT_INST; the HLT word itself is presented with valid_r=1.
REQ-027 HALT to RUN only via branch_taken or rst.
REQ-028 fetch_count SHALL increment by 1 on each REQ-022 load and saturate at 16'hFFFF.
REQ-029 halted SHALL be a registered output equal to (state==HALT).
REQ-030 Latency: the word at imem_addr in cycle N appears on inst_r after edge N+1.

Reset
REQ-031 rst=1 SHALL immediately, without waiting for a clock edge, set pc_f=RESET_PC, inst_r=NOP_INST, pc_r=16'h0000, valid_r=0, fetch_count=0, state=RUN.
REQ-032 rst asserted mid-stall, mid-branch, or in HALT SHALL produce the REQ-031 values, with no residual state.
REQ-033 The first edge after rst deasserts SHALL fetch from RESET_PC.

Verification
REQ-034 Reset, en_f=en_r=1, imem[i]=16'h1000+i, 4 cycles -> inst_r 1000,1001,1002,1003; pc_r 1,2,3,4; fetch_count=4.
REQ-035 Stall: en_f=0, en_r=0 for 2 cycles, then en_f=0, en_r=1 for 1 cycle -> inst_r held 2 cycles, then NOP_INST with valid_r=0; imem_addr unchanged for all 3 cycles.
REQ-036 branch_taken=1, target 16'h0040, while en_f=en_r=0 -> next cycle imem_addr=0040, inst_r=NOP_INST, valid_r=0; the following cycle inst_r=imem[0040].
REQ-037 imem[5]=HLT_INST -> HLT appears with valid_r=1, halted=1; imem_addr stays 6; later inst_r=NOP_INST; branch to 16'h0010 clears halted and resumes fetch.
REQ-038 pc_f=16'hFFFF with en_f=en_r=1 -> imem_addr=0000 next cycle, pc_r=0000; fetch_count saturates at FFFF when preloaded near limit.
REQ-039 Assert rst asynchronously between edges during HALT -> outputs take REQ-031 values before the next edge.
